button_conditioner: RTL

Conditions the raw push-button inputs of the clock/stopwatch/alarm design before they reach the mode FSM. Each button gets a two-flop synchronizer, tick-qualified debounce, and press/release edge pulses. Each button also gets long-press detection and auto-repeat, so the FSM can use long-hold for setting entry and repeat for fast value increment. Every button lane is independent and identical.

---
 rtl/button_conditioner.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// button_conditioner
// Conditions raw push-button inputs for the mode FSM. Every lane runs the
// same pipeline: two-flop synchronizer, tick-qualified debounce, press and
// release pulses, long-press detection and auto-repeat while held long.
// All lanes are independent; simultaneous events are reported in parallel.

module button_conditioner #(
  parameter int NUM_BTN        = 3,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int LONG_TICKS     = 100,
  parameter int REPEAT_TICKS   = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long,
  output logic [NUM_BTN-1:0] btn_repeat
);

  // Counter widths: each counter only ever has to reach its own limit.
  localparam int DB_W   = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HOLD_W = $clog2(LONG_TICKS + 1);
  localparam int REP_W  = $clog2(REPEAT_TICKS + 1);

  localparam logic [DB_W-1:0]   DB_ZERO   = '0;
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = '0;
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS);
  localparam logic [REP_W-1:0]  REP_ZERO  = '0;
  localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_TICKS);

  // A single debounce tick is enough when the limit is 1; the FSM then
  // skips the debounce states entirely.
  localparam logic SINGLE_TICK_DB = (DEBOUNCE_TICKS == 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_DB  = 3'd1,
    HELD      = 3'd2,
    LONG_HELD = 3'd3,
    REL_DB    = 3'd4
  } lane_state_t;

  logic [NUM_BTN-1:0] sync1_reg;
  logic [NUM_BTN-1:0] sync2_reg;

  // Two-flop synchronizer; btn_raw is asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_lane
      logic              s_bit;
      lane_state_t       state_reg,    state_next;
      logic [DB_W-1:0]   db_cnt_reg,   db_cnt_next;
      logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
      logic [REP_W-1:0]  rep_cnt_reg,  rep_cnt_next;
      logic              ret_long_reg, ret_long_next;
      logic              level_reg,    level_next;
      logic              press_reg,    press_next;
      logic              release_reg,  release_next;
      logic              long_reg,     long_next;
      logic              repeat_reg,   repeat_next;
      logic [DB_W-1:0]   db_inc;
      logic [HOLD_W-1:0] hold_inc;
      logic [REP_W-1:0]  rep_inc;

      assign s_bit    = sync2_reg[gi];
      assign db_inc   = db_cnt_reg + DB_ONE;
      assign hold_inc = hold_cnt_reg + HOLD_ONE;
      assign rep_inc  = rep_cnt_reg + REP_ONE;

      // State, counters and registered outputs; pulses are rebuilt every clk.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg    <= IDLE;
          db_cnt_reg   <= DB_ZERO;
          hold_cnt_reg <= HOLD_ZERO;
          rep_cnt_reg  <= REP_ZERO;
          ret_long_reg <= 1'b0;
          level_reg    <= 1'b0;
          press_reg    <= 1'b0;
          release_reg  <= 1'b0;
          long_reg     <= 1'b0;
          repeat_reg   <= 1'b0;
        end else begin
          state_reg    <= state_next;
          db_cnt_reg   <= db_cnt_next;
          hold_cnt_reg <= hold_cnt_next;
          rep_cnt_reg  <= rep_cnt_next;
          ret_long_reg <= ret_long_next;
          level_reg    <= level_next;
          press_reg    <= press_next;
          release_reg  <= release_next;
          long_reg     <= long_next;
          repeat_reg   <= repeat_next;
        end
      end

      // Next-state logic; nothing moves and no pulse fires unless tick=1.
      always_comb begin
        state_next    = state_reg;
        db_cnt_next   = db_cnt_reg;
        hold_cnt_next = hold_cnt_reg;
        rep_cnt_next  = rep_cnt_reg;
        ret_long_next = ret_long_reg;
        level_next    = level_reg;
        press_next    = 1'b0;
        release_next  = 1'b0;
        long_next     = 1'b0;
        repeat_next   = 1'b0;

        if (tick) begin
          case (state_reg)
            IDLE: begin
              if (s_bit) begin
                if (SINGLE_TICK_DB) begin
                  state_next    = HELD;
                  level_next    = 1'b1;
                  press_next    = 1'b1;
                  hold_cnt_next = HOLD_ZERO;
                  db_cnt_next   = DB_ZERO;
                end else begin
                  state_next  = PRESS_DB;
                  db_cnt_next = DB_ONE;
                end
              end
            end

            PRESS_DB: begin
              if (s_bit) begin
                if (db_inc == DB_LAST) begin
                  state_next    = HELD;
                  level_next    = 1'b1;
                  press_next    = 1'b1;
                  hold_cnt_next = HOLD_ZERO;
                  db_cnt_next   = DB_ZERO;
                end else begin
                  db_cnt_next = db_inc;
                end
              end else begin
                // Bounce: abandon the press silently.
                state_next  = IDLE;
                db_cnt_next = DB_ZERO;
              end
            end

            HELD: begin
              if (s_bit) begin
                hold_cnt_next = hold_inc;
                if (hold_inc == HOLD_LAST) begin
                  state_next   = LONG_HELD;
                  long_next    = 1'b1;
                  rep_cnt_next = REP_ZERO;
                end
              end else if (SINGLE_TICK_DB) begin
                state_next    = IDLE;
                level_next    = 1'b0;
                release_next  = 1'b1;
                db_cnt_next   = DB_ZERO;
                hold_cnt_next = HOLD_ZERO;
                rep_cnt_next  = REP_ZERO;
                ret_long_next = 1'b0;
              end else begin
                state_next    = REL_DB;
                db_cnt_next   = DB_ONE;
                ret_long_next = 1'b0;
              end
            end

            LONG_HELD: begin
              if (s_bit) begin
                if (rep_inc == REP_LAST) begin
                  repeat_next  = 1'b1;
                  rep_cnt_next = REP_ZERO;
                end else begin
                  rep_cnt_next = rep_inc;
                end
              end else if (SINGLE_TICK_DB) begin
                state_next    = IDLE;
                level_next    = 1'b0;
                release_next  = 1'b1;
                db_cnt_next   = DB_ZERO;
                hold_cnt_next = HOLD_ZERO;
                rep_cnt_next  = REP_ZERO;
                ret_long_next = 1'b0;
              end else begin
                state_next    = REL_DB;
                db_cnt_next   = DB_ONE;
                ret_long_next = 1'b1;
              end
            end

            REL_DB: begin
              // hold_cnt and rep_cnt stay frozen so a glitch does not
              // disturb the long-press or repeat schedule.
              if (!s_bit) begin
                if (db_inc == DB_LAST) begin
                  state_next    = IDLE;
                  level_next    = 1'b0;
                  release_next  = 1'b1;
                  db_cnt_next   = DB_ZERO;
                  hold_cnt_next = HOLD_ZERO;
                  rep_cnt_next  = REP_ZERO;
                  ret_long_next = 1'b0;
                end else begin
                  db_cnt_next = db_inc;
                end
              end else begin
                state_next  = ret_long_reg ? LONG_HELD : HELD;
                db_cnt_next = DB_ZERO;
              end
            end

            default: begin
              state_next    = IDLE;
              level_next    = 1'b0;
              db_cnt_next   = DB_ZERO;
              hold_cnt_next = HOLD_ZERO;
              rep_cnt_next  = REP_ZERO;
              ret_long_next = 1'b0;
            end
          endcase
        end
      end

      assign btn_level[gi]   = level_reg;
      assign btn_press[gi]   = press_reg;
      assign btn_release[gi] = release_reg;
      assign btn_long[gi]    = long_reg;
      assign btn_repeat[gi]  = repeat_reg;
    end
  endgenerate

endmodule
